// File: rtl/pnu_mod_counter_if.sv
// Control and status bundle of the modulo-N counter; master drives controls, slave is the counter.
// Pure wiring, no latency and no backpressure.
interface pnu_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_gray;
    logic             tc;
    logic             wrap;
    logic             load_err;

    modport master (
        output clear, load, load_val, en, up,
        input  cnt, cnt_gray, tc, wrap, load_err
    );

    modport slave (
        input  clear, load, load_val, en, up,
        output cnt, cnt_gray, tc, wrap, load_err
    );
endinterface

// File: rtl/pnu_mod_counter.sv
// Modulo-MOD up/down counter: clear, clamped load, wrap/load_err pulses, Gray view.
// Latency: a control sampled at an edge shows on cnt right after it; never stalls, no backpressure.
module pnu_mod_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic               clk,
    input  logic               rst,
    pnu_mod_counter_if.slave   bus
);
    if (WIDTH < 1 || WIDTH > 62 || MOD < 2 || longint'(MOD) > (longint'(1) << WIDTH)) begin : g_bad_param
        $fatal(1, "pnu_mod_counter: illegal WIDTH/MOD combination");
    end

    localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_q;
    logic             wrap_nxt;
    logic             err_q;
    logic             err_nxt;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (cnt_q == CNT_MAX);
    assign at_zero = (cnt_q == CNT_ZERO);

    always_comb begin
        cnt_nxt  = cnt_q;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (bus.clear) begin
            cnt_nxt = CNT_ZERO;
        end else if (bus.load) begin
            // Out-of-range loads saturate to the top of the range and flag it
            if (bus.load_val > CNT_MAX) begin
                cnt_nxt = CNT_MAX;
                err_nxt = 1'b1;
            end else begin
                cnt_nxt = bus.load_val;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                if (at_max) begin
                    cnt_nxt  = CNT_ZERO;
                    wrap_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CNT_ONE;
                end
            end else begin
                if (at_zero) begin
                    cnt_nxt  = CNT_MAX;
                    wrap_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_q - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= CNT_ZERO;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            wrap_q <= wrap_nxt;
            err_q  <= err_nxt;
        end
    end

    // tc looks only at en/up/cnt so it can be used to anticipate the next wrap
    assign bus.tc       = bus.en & ((bus.up & at_max) | (~bus.up & at_zero));
    assign bus.cnt      = cnt_q;
    assign bus.cnt_gray = cnt_q ^ (cnt_q >> 1);
    assign bus.wrap     = wrap_q;
    assign bus.load_err = err_q;
endmodule
